// File: rtl/control_sequencer.sv
// control_sequencer: one-instruction-at-a-time control sequencer producing registered strobes.
// Latency: strobes appear one cycle after acceptance; non-memory ops sustain one instruction per cycle.
// Backpressure: instr_ready is low while a memory access is outstanding, in HALT, and during reset.
//
// Ports:
//   clk, reset (async, active-low)
//   instr_valid/instr_ready handshake with opcode instrOP and LOAD high-enable he
//   mem_done completes an outstanding READ/WRITE; int_req (level) is taken in IDLE/HALT
//   registered strobes: alu_use_const push pop dreg_we dreg_we_high mem_write mem_read
//                       jumpc jumpr getIntID getPC loadConst
//   status: halted, int_ack/illegal/mem_err pulses, retired instruction counter
module control_sequencer #(
    parameter int OPW  = 4,
    parameter int TOW  = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [OPW-1:0]  instrOP,
    input  logic            he,
    input  logic            mem_done,
    input  logic            int_req,
    output logic            instr_ready,
    output logic            alu_use_const,
    output logic            push,
    output logic            pop,
    output logic            dreg_we,
    output logic            dreg_we_high,
    output logic            mem_write,
    output logic            mem_read,
    output logic            jumpc,
    output logic            jumpr,
    output logic            getIntID,
    output logic            getPC,
    output logic            loadConst,
    output logic            halted,
    output logic            int_ack,
    output logic            illegal,
    output logic            mem_err,
    output logic [CNTW-1:0] retired
);

    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [3:0] OP_READ   = 4'hE;
    localparam logic [3:0] OP_WRITE  = 4'hD;
    localparam logic [3:0] OP_INTID  = 4'hC;
    localparam logic [3:0] OP_PUSH   = 4'hB;
    localparam logic [3:0] OP_POP    = 4'hA;
    localparam logic [3:0] OP_JUMP   = 4'h9;
    localparam logic [3:0] OP_JUMPR  = 4'h8;
    localparam logic [3:0] OP_LOAD   = 4'h7;
    localparam logic [3:0] OP_SAVPC  = 4'h5;
    localparam logic [3:0] OP_ARITHC = 4'h1;
    localparam logic [3:0] OP_ARITH  = 4'h0;

    // Last MEM cycle count value before timeout: 2^TOW-2 means the access
    // has been outstanding for 2^TOW-1 cycles when this value is reached.
    localparam logic [TOW-1:0] TO_LAST = ~TOW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic alu_use_const;
        logic push;
        logic pop;
        logic dreg_we;
        logic dreg_we_high;
        logic mem_write;
        logic mem_read;
        logic jumpc;
        logic jumpr;
        logic get_int_id;
        logic get_pc;
        logic load_const;
    } strobe_t;

    state_t          state_q, state_d;
    strobe_t         strb_q, strb_d;
    logic            ready_q, ready_d;
    logic            halted_q, halted_d;
    logic            int_ack_q, int_ack_d;
    logic            illegal_q, illegal_d;
    logic            mem_err_q, mem_err_d;
    logic [CNTW-1:0] retired_q, retired_d;
    logic [TOW-1:0]  to_cnt_q, to_cnt_d;

    // Opcode decode
    logic [3:0] op_lo;
    logic       ext_zero;
    logic       op_legal;
    logic       op_is_mem;
    strobe_t    dec_strb;

    always_comb begin
        op_lo     = instrOP[3:0];
        ext_zero  = ((instrOP >> 4) == '0);
        op_legal  = ext_zero && (op_lo != 4'h3) && (op_lo != 4'h2);
        op_is_mem = (op_lo == OP_READ) || (op_lo == OP_WRITE);
        dec_strb  = '0;
        case (op_lo)
            OP_READ:   dec_strb.mem_read = 1'b1;
            OP_WRITE:  dec_strb.mem_write = 1'b1;
            OP_INTID:  begin dec_strb.get_int_id = 1'b1; dec_strb.dreg_we = 1'b1; end
            OP_PUSH:   dec_strb.push = 1'b1;
            OP_POP:    begin dec_strb.pop = 1'b1; dec_strb.dreg_we = 1'b1; end
            OP_JUMP:   dec_strb.jumpc = 1'b1;
            OP_JUMPR:  dec_strb.jumpr = 1'b1;
            OP_LOAD:   begin
                dec_strb.load_const   = 1'b1;
                dec_strb.dreg_we      = 1'b1;
                dec_strb.dreg_we_high = he;
            end
            OP_SAVPC:  begin dec_strb.get_pc = 1'b1; dec_strb.dreg_we = 1'b1; end
            OP_ARITHC: begin dec_strb.alu_use_const = 1'b1; dec_strb.dreg_we = 1'b1; end
            OP_ARITH:  dec_strb.dreg_we = 1'b1;
            default:   ; // HALT, BRANCH, RETI and illegal codes drive no strobes
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        strb_d    = '0;
        halted_d  = halted_q;
        int_ack_d = 1'b0;
        illegal_d = 1'b0;
        mem_err_d = 1'b0;
        retired_d = retired_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Interrupt takes priority over a presented instruction.
                if (int_req) begin
                    int_ack_d = 1'b1;
                end else if (instr_valid && ready_q) begin
                    if (!op_legal) begin
                        illegal_d = 1'b1;
                    end else begin
                        strb_d   = dec_strb;
                        to_cnt_d = '0;
                        if (op_is_mem) begin
                            state_d = ST_MEM;
                        end else begin
                            retired_d = retired_q + CNTW'(1);
                            if (op_lo == OP_HALT) begin
                                state_d  = ST_HALT;
                                halted_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_MEM: begin
                if (mem_done) begin
                    // READ data lands in the register file the cycle after completion.
                    strb_d.dreg_we = strb_q.mem_read;
                    retired_d      = retired_q + CNTW'(1);
                    to_cnt_d       = '0;
                    state_d        = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    mem_err_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = ST_IDLE;
                end else begin
                    strb_d.mem_read  = strb_q.mem_read;
                    strb_d.mem_write = strb_q.mem_write;
                    to_cnt_d         = to_cnt_q + TOW'(1);
                end
            end
            ST_HALT: begin
                if (int_req) begin
                    int_ack_d = 1'b1;
                    halted_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                halted_d = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            strb_q    <= '0;
            ready_q   <= 1'b0;
            halted_q  <= 1'b0;
            int_ack_q <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            retired_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            ready_q   <= ready_d;
            halted_q  <= halted_d;
            int_ack_q <= int_ack_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            retired_q <= retired_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign instr_ready   = ready_q;
    assign alu_use_const = strb_q.alu_use_const;
    assign push          = strb_q.push;
    assign pop           = strb_q.pop;
    assign dreg_we       = strb_q.dreg_we;
    assign dreg_we_high  = strb_q.dreg_we_high;
    assign mem_write     = strb_q.mem_write;
    assign mem_read      = strb_q.mem_read;
    assign jumpc         = strb_q.jumpc;
    assign jumpr         = strb_q.jumpr;
    assign getIntID      = strb_q.get_int_id;
    assign getPC         = strb_q.get_pc;
    assign loadConst     = strb_q.load_const;
    assign halted        = halted_q;
    assign int_ack       = int_ack_q;
    assign illegal       = illegal_q;
    assign mem_err       = mem_err_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench for control_sequencer.
// Latency: expected per-cycle outputs are queued by the driver and popped one cycle later by the monitor.
// Backpressure: the driver only presents instructions when its model says the sequencer is ready.
module tb_control_sequencer;

    localparam int OPW  = 6;
    localparam int TOW  = 3;
    localparam int CNTW = 4;

    // strobe bit positions inside the expected strobe vector
    localparam int S_ALUC = 11, S_PUSH = 10, S_POP = 9, S_DWE = 8, S_DWEH = 7, S_MW = 6;
    localparam int S_MR = 5, S_JC = 4, S_JR = 3, S_GID = 2, S_GPC = 1, S_LC = 0;

    typedef struct packed {
        logic [11:0]     strb;
        logic            halted;
        logic            int_ack;
        logic            illegal;
        logic            mem_err;
        logic            ready;
        logic [CNTW-1:0] retired;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            instr_valid;
    logic [OPW-1:0]  instrOP;
    logic            he;
    logic            mem_done;
    logic            int_req;
    logic            instr_ready;
    logic            alu_use_const, push, pop, dreg_we, dreg_we_high, mem_write, mem_read;
    logic            jumpc, jumpr, getIntID, getPC, loadConst;
    logic            halted, int_ack, illegal, mem_err;
    logic [CNTW-1:0] retired;

    control_sequencer #(.OPW(OPW), .TOW(TOW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instrOP(instrOP), .he(he),
        .mem_done(mem_done), .int_req(int_req), .instr_ready(instr_ready),
        .alu_use_const(alu_use_const), .push(push), .pop(pop), .dreg_we(dreg_we),
        .dreg_we_high(dreg_we_high), .mem_write(mem_write), .mem_read(mem_read),
        .jumpc(jumpc), .jumpr(jumpr), .getIntID(getIntID), .getPC(getPC), .loadConst(loadConst),
        .halted(halted), .int_ack(int_ack), .illegal(illegal), .mem_err(mem_err), .retired(retired)
    );

    exp_t act_v;
    assign act_v = {alu_use_const, push, pop, dreg_we, dreg_we_high, mem_write, mem_read,
                    jumpc, jumpr, getIntID, getPC, loadConst,
                    halted, int_ack, illegal, mem_err, instr_ready, retired};

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_retired = 0;
    bit    running  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input exp_t a, input exp_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got strb=%03h halted=%0b int_ack=%0b illegal=%0b mem_err=%0b ready=%0b retired=%0d, expected strb=%03h halted=%0b int_ack=%0b illegal=%0b mem_err=%0b ready=%0b retired=%0d",
                     name, a.strb, a.halted, a.int_ack, a.illegal, a.mem_err, a.ready, a.retired,
                     e.strb, e.halted, e.int_ack, e.illegal, e.mem_err, e.ready, e.retired);
        end
    endtask

    // Strobe set for each opcode, straight from the opcode table.
    function automatic logic [11:0] strb_for(input logic [3:0] op, input logic h);
        logic [11:0] s;
        s = '0;
        case (op)
            4'hE: s[S_MR] = 1'b1;
            4'hD: s[S_MW] = 1'b1;
            4'hC: begin s[S_GID] = 1'b1; s[S_DWE] = 1'b1; end
            4'hB: s[S_PUSH] = 1'b1;
            4'hA: begin s[S_POP] = 1'b1; s[S_DWE] = 1'b1; end
            4'h9: s[S_JC] = 1'b1;
            4'h8: s[S_JR] = 1'b1;
            4'h7: begin s[S_LC] = 1'b1; s[S_DWE] = 1'b1; s[S_DWEH] = h; end
            4'h5: begin s[S_GPC] = 1'b1; s[S_DWE] = 1'b1; end
            4'h1: begin s[S_ALUC] = 1'b1; s[S_DWE] = 1'b1; end
            4'h0: s[S_DWE] = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    function automatic exp_t mk(input logic [11:0] s, input logic h, input logic ack,
                                input logic ill, input logic err, input logic rdy);
        exp_t e;
        e.strb    = s;
        e.halted  = h;
        e.int_ack = ack;
        e.illegal = ill;
        e.mem_err = err;
        e.ready   = rdy;
        e.retired = CNTW'(m_retired);
        return e;
    endfunction

    function automatic void retire();
        m_retired = (m_retired + 1) % (1 << CNTW);
    endfunction

    // Drive one edge worth of inputs and queue the outputs expected after that edge.
    task automatic step(input string tag, input logic v, input logic [OPW-1:0] op, input logic h,
                        input logic md, input logic ir, input exp_t e);
        instr_valid = v;
        instrOP     = op;
        he          = h;
        mem_done    = md;
        int_req     = ir;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        step("idle", 1'b0, OPW'($urandom), 1'($urandom), 1'($urandom), 1'b0, mk('0, 0, 0, 0, 0, 1));
    endtask

    task automatic irq_idle();
        step("irq_idle", 1'($urandom), OPW'($urandom), 1'($urandom), 1'($urandom), 1'b1,
             mk('0, 0, 1, 0, 0, 1));
    endtask

    task automatic nonmem(input logic [3:0] op, input logic h);
        retire();
        step("nonmem", 1'b1, {2'b00, op}, h, 1'($urandom), 1'b0, mk(strb_for(op, h), 0, 0, 0, 0, 1));
    endtask

    task automatic bad_op(input logic [OPW-1:0] op);
        step("illegal", 1'b1, op, 1'($urandom), 1'($urandom), 1'b0, mk('0, 0, 0, 1, 0, 1));
    endtask

    // done_cycle: MEM cycle (1-based) in which mem_done is presented; 0 means never.
    task automatic mem_op(input bit is_read, input int done_cycle);
        logic [3:0]  op;
        logic [11:0] s;
        int          limit;
        limit = (1 << TOW) - 1;
        op = is_read ? 4'hE : 4'hD;
        s  = strb_for(op, 1'b0);
        step("mem_accept", 1'b1, {2'b00, op}, 1'($urandom), 1'($urandom), 1'b0, mk(s, 0, 0, 0, 0, 0));
        for (int c = 1; c <= limit; c++) begin
            if (c == done_cycle) begin
                retire();
                step("mem_done", 1'($urandom), OPW'($urandom), 1'($urandom), 1'b1, 1'($urandom),
                     mk(is_read ? 12'h100 : 12'h000, 0, 0, 0, 0, 1));
                break;
            end else if (c == limit) begin
                step("mem_timeout", 1'($urandom), OPW'($urandom), 1'($urandom), 1'b0, 1'($urandom),
                     mk('0, 0, 0, 0, 1, 1));
            end else begin
                step("mem_wait", 1'($urandom), OPW'($urandom), 1'($urandom), 1'b0, 1'($urandom),
                     mk(s, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic halt_op(input int wait_cycles);
        retire();
        step("halt_accept", 1'b1, 6'h0F, 1'($urandom), 1'($urandom), 1'b0, mk('0, 1, 0, 0, 0, 0));
        for (int i = 0; i < wait_cycles; i++)
            step("halt_wait", 1'($urandom), OPW'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                 mk('0, 1, 0, 0, 0, 0));
        step("halt_wake", 1'b1, {2'b00, 4'($urandom)}, 1'($urandom), 1'($urandom), 1'b1,
             mk('0, 0, 1, 0, 0, 1));
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        reset       = 1'b1;
        running     = 1'b1;
        m_retired   = 0;
        step("post_reset", 1'b0, '0, 1'b0, 1'b1, 1'b0, mk('0, 0, 0, 0, 0, 1));
    endtask

    // Monitor: compare every cycle's outputs with the queued expectation.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (reset && running) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got no expectation, required one per cycle");
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check(t, act_v, e);
                end
            end
        end
    end

    initial begin
        logic [3:0]     op4;
        logic [OPW-1:0] opx;
        reset       = 1'b0;
        instr_valid = 1'b0;
        instrOP     = '0;
        he          = 1'b0;
        mem_done    = 1'b0;
        int_req     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_state", act_v, mk('0, 0, 0, 0, 0, 0));
        release_reset();

        // back-to-back ARITH, LOAD(he=1), SAVPC
        nonmem(4'h0, 1'b0);
        nonmem(4'h7, 1'b1);
        nonmem(4'h5, 1'b0);
        idle_cycle();
        // READ completing in the 4th MEM cycle, WRITE timing out
        mem_op(1'b1, 4);
        mem_op(1'b0, 0);
        // HALT, wake on int_req together with instr_valid
        halt_op(2);
        // illegal opcodes
        bad_op(6'h10);
        bad_op(6'h03);
        bad_op(6'h02);
        irq_idle();
        // every legal non-memory opcode, both he values
        nonmem(4'hC, 1'b0); nonmem(4'hB, 1'b1); nonmem(4'hA, 1'b0); nonmem(4'h9, 1'b0);
        nonmem(4'h8, 1'b1); nonmem(4'h7, 1'b0); nonmem(4'h6, 1'b1); nonmem(4'h4, 1'b0);
        nonmem(4'h1, 1'b1);

        // reset in the middle of a READ
        step("rd_accept", 1'b1, 6'h0E, 1'b0, 1'b0, 1'b0, mk(12'h020, 0, 0, 0, 0, 0));
        step("rd_wait", 1'b0, '0, 1'b0, 1'b0, 1'b0, mk(12'h020, 0, 0, 0, 0, 0));
        @(negedge clk);
        #2;
        reset     = 1'b0;
        m_retired = 0;
        #1;
        check("reset_async", act_v, mk('0, 0, 0, 0, 0, 0));
        mem_done = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold", act_v, mk('0, 0, 0, 0, 0, 0));
        release_reset();
        idle_cycle();
        mem_op(1'b0, 0);

        // retired counter wrap
        for (int i = 0; i < 17; i++) nonmem(4'h0, 1'($urandom));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    do op4 = 4'($urandom_range(0, 15));
                    while (op4 == 4'hE || op4 == 4'hD || op4 == 4'hF || op4 == 4'h3 || op4 == 4'h2);
                    nonmem(op4, 1'($urandom));
                end
                5: mem_op(1'($urandom), $urandom_range(0, 7));
                6: begin
                    if ($urandom_range(0, 1) == 1) opx = {2'($urandom_range(1, 3)), 4'($urandom)};
                    else opx = {2'b00, 4'($urandom_range(2, 3))};
                    bad_op(opx);
                end
                7: halt_op($urandom_range(0, 3));
                8: idle_cycle();
                default: irq_idle();
            endcase
        end

        @(negedge clk);
        #1;
        running = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
